// File: rtl/exec_mem_stage.sv
// exec_mem_stage: MIPS execute stage with forwarding, ALU and the EX/MEM register. Latency: 1 cycle; with `EXEC_MUL_EN a mul takes 34 cycles.
// Backpressure: stallE holds F/D/E while the multiplier runs, and bubbles enter M during that time.
module exec_mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemToRegE,
  input  logic        MemWriteE,
  input  logic        ALUSrcE,
  input  logic        RegDstE,
  input  logic        RegWE,
  input  logic [2:0]  ALUOPE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] SignImmE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ALUOutMIn,
  input  logic [31:0] ResultW,
  output logic [4:0]  WriteRegE,
  output logic        stallE,
  output logic        MemToRegM,
  output logic        MemWriteM,
  output logic        RegWM,
  output logic [31:0] ALUOutM,
  output logic [31:0] WriteDataM,
  output logic [4:0]  WriteRegM
);

  logic [31:0] src_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;
  logic [31:0] alu_res;
  logic [31:0] alu_out;

  always_comb begin
    src_a = RD1E;
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUOutMIn;
      default: src_a = RD1E;
    endcase
  end

  always_comb begin
    fwd_b = RD2E;
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUOutMIn;
      default: fwd_b = RD2E;
    endcase
  end

  assign src_b     = ALUSrcE ? SignImmE : fwd_b;
  assign WriteRegE = RegDstE ? RdE : RtE;

  always_comb begin
    alu_res = '0;
    case (ALUOPE)
      3'b000:  alu_res = src_a + src_b;
      3'b001:  alu_res = src_a - src_b;
      3'b010:  alu_res = src_a & src_b;
      3'b011:  alu_res = src_a | src_b;
      3'b100:  alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
      3'b101:  alu_res = src_a ^ src_b;
      3'b110:  alu_res = ~(src_a | src_b);
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} mul_state_t;

  mul_state_t  state;
  mul_state_t  state_nxt;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [4:0]  count;
  logic        mul_start;

  assign mul_start = (state == IDLE) && (ALUOPE == 3'b111);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (mul_start) begin
            mcand  <= src_a;
            mplier <= src_b;
            acc    <= '0;
            count  <= '0;
          end
        end
        MUL: begin
          // Shift-add over 32 steps; only the low word of the product is kept.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    stallE    = 1'b0;
    alu_out   = alu_res;
    case (state)
      IDLE: begin
        if (mul_start) begin
          state_nxt = MUL;
          stallE    = 1'b1;
        end
      end
      MUL: begin
        stallE = 1'b1;
        if (count == 5'd31) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        alu_out   = acc;
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  assign stallE  = 1'b0;
  assign alu_out = alu_res;
`endif

  always_ff @(posedge clk) begin
    if (reset || stallE) begin
      MemToRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      RegWM      <= 1'b0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
    end else begin
      MemToRegM  <= MemToRegE;
      MemWriteM  <= MemWriteE;
      RegWM      <= RegWE;
      ALUOutM    <= alu_out;
      WriteDataM <= fwd_b;
      WriteRegM  <= WriteRegE;
    end
  end

endmodule

// File: tb/tb_exec_mem_stage.sv
// Directed bench for exec_mem_stage: vector table for single-cycle ops, hand sequences for reset and the multiplier.
module tb_exec_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemToRegE, MemWriteE, ALUSrcE, RegDstE, RegWE;
  logic [2:0]  ALUOPE;
  logic [31:0] RD1E, RD2E, SignImmE;
  logic [4:0]  RtE, RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ALUOutMIn, ResultW;
  logic [4:0]  WriteRegE;
  logic        stallE;
  logic        MemToRegM, MemWriteM, RegWM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;

  exec_mem_stage dut (
    .clk(clk), .reset(reset),
    .MemToRegE(MemToRegE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .RegWE(RegWE),
    .ALUOPE(ALUOPE), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .RtE(RtE), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUOutMIn(ALUOutMIn), .ResultW(ResultW),
    .WriteRegE(WriteRegE), .stallE(stallE),
    .MemToRegM(MemToRegM), .MemWriteM(MemWriteM), .RegWM(RegWM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rd1, rd2, imm, fwdm, fwdw;
    logic        alusrc, regdst, memtoreg, memwrite, regw;
    logic [1:0]  fa, fb;
    logic [4:0]  rt, rd;
    logic [31:0] exp_alu, exp_wd;
    logic [4:0]  exp_wreg;
  } vec_t;

  vec_t vecs[$];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive_idle();
    MemToRegE = 0; MemWriteE = 0; ALUSrcE = 0; RegDstE = 0; RegWE = 0;
    ALUOPE = 3'b000; RD1E = 0; RD2E = 0; SignImmE = 0; RtE = 0; RdE = 0;
    ForwardAE = 0; ForwardBE = 0; ALUOutMIn = 0; ResultW = 0;
  endtask

  task automatic apply(input vec_t v);
    ALUOPE = v.op; RD1E = v.rd1; RD2E = v.rd2; SignImmE = v.imm;
    ALUOutMIn = v.fwdm; ResultW = v.fwdw; ALUSrcE = v.alusrc; RegDstE = v.regdst;
    MemToRegE = v.memtoreg; MemWriteE = v.memwrite; RegWE = v.regw;
    ForwardAE = v.fa; ForwardBE = v.fb; RtE = v.rt; RdE = v.rd;
  endtask

  task automatic add_vec(input string n, input logic [2:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic alusrc, input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] fwdm, input logic [31:0] fwdw, input logic mw,
                         input logic [31:0] ealu, input logic [31:0] ewd);
    vec_t v;
    v.name = n; v.op = op; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.alusrc = alusrc;
    v.fa = fa; v.fb = fb; v.fwdm = fwdm; v.fwdw = fwdw;
    v.memwrite = mw; v.regw = ~mw; v.memtoreg = 1'b0;
    v.regdst = vecs.size() % 2 == 0;
    v.rt = 5'(vecs.size() + 1); v.rd = 5'(vecs.size() + 17);
    v.exp_alu = ealu; v.exp_wd = ewd;
    v.exp_wreg = v.regdst ? v.rd : v.rt;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_bubble(input string n);
    chk({n, "_alu"}, ALUOutM, 32'h0);
    chk({n, "_wd"}, WriteDataM, 32'h0);
    chk({n, "_ctl"}, {29'd0, MemToRegM, MemWriteM, RegWM}, 32'h0);
    chk({n, "_wreg"}, {27'd0, WriteRegM}, 32'h0);
  endtask

`ifdef EXEC_MUL_EN
  // Runs one mul from its first cycle to the DONE edge and checks stall/bubbles/product.
  task automatic run_mul(input string n, input logic [31:0] a, input logic [31:0] b, input logic [31:0] prod);
    int stalls = 0;
    drive_idle();
    ALUOPE = 3'b111; RD1E = a; RD2E = b; RegWE = 1; RtE = 5'd9;
    for (int c = 0; c <= 33; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Operands must already be latched; disturb every forward source.
        ForwardAE = 2'b01; ForwardBE = 2'b10; ResultW = 32'hDEAD_BEEF; ALUOutMIn = 32'h1234_5678;
        RD1E = 32'hFFFF_FFFF; RD2E = 32'h7;
      end
      if (stallE) stalls++;
      if (c == 33) chk({n, "_done_stall"}, {31'd0, stallE}, 32'h0);
      step();
      if (c < 33) chk({n, "_bubble_regw"}, {31'd0, RegWM}, 32'h0);
    end
    chk({n, "_prod"}, ALUOutM, prod);
    chk({n, "_regw"}, {31'd0, RegWM}, 32'h1);
    chk({n, "_stall_cycles"}, 32'(stalls), 32'd33);
  endtask
`endif

  initial begin
    add_vec("add",      3'b000, 32'd5,        32'd7,        32'd0, 0, 2'b00, 2'b00, 32'd0,     32'd0, 0, 32'd12,        32'd7);
    add_vec("fwd_a_m",  3'b000, 32'd0,        32'h55,       32'd4, 1, 2'b10, 2'b00, 32'h100,   32'd0, 0, 32'h104,       32'h55);
    add_vec("fwd_b_w",  3'b000, 32'h20,       32'd1,        32'd8, 1, 2'b00, 2'b01, 32'd0,     32'd9, 1, 32'h28,        32'd9);
    add_vec("slt_neg",  3'b100, 32'hFFFFFFFF, 32'd1,        32'd0, 0, 2'b00, 2'b00, 32'd0,     32'd0, 0, 32'h1,         32'd1);
    add_vec("sub",      3'b001, 32'd3,        32'd5,        32'd0, 0, 2'b00, 2'b00, 32'd0,     32'd0, 0, 32'hFFFFFFFE,  32'd5);
    add_vec("and",      3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 0, 2'b00, 2'b00, 32'd0,     32'd0, 0, 32'hF000F000,  32'hFF00FF00);
    add_vec("or",       3'b011, 32'h0F0F0000, 32'h000000FF, 32'd0, 0, 2'b00, 2'b00, 32'd0,     32'd0, 0, 32'h0F0F00FF,  32'h000000FF);
    add_vec("xor",      3'b101, 32'hFFFF0000, 32'h0F0F0F0F, 32'd0, 0, 2'b00, 2'b00, 32'd0,     32'd0, 0, 32'hF0F00F0F,  32'h0F0F0F0F);
    add_vec("nor",      3'b110, 32'h000000F0, 32'h0000000F, 32'd0, 0, 2'b00, 2'b00, 32'd0,     32'd0, 0, 32'hFFFFFF00,  32'h0000000F);
    add_vec("slt_sgn",  3'b100, 32'd2,        32'hFFFFFFFF, 32'd0, 0, 2'b00, 2'b00, 32'd0,     32'd0, 0, 32'h0,         32'hFFFFFFFF);
    add_vec("fwd_rsv",  3'b000, 32'd10,       32'd1,        32'd0, 0, 2'b11, 2'b11, 32'd999,   32'd77, 0, 32'd11,       32'd1);
    add_vec("fwd_b_m",  3'b000, 32'd1,        32'd3,        32'd0, 0, 2'b00, 2'b10, 32'h40,    32'd0, 0, 32'h41,        32'h40);
    add_vec("add_wrap", 3'b000, 32'hFFFFFFFF, 32'd2,        32'd0, 0, 2'b00, 2'b00, 32'd0,     32'd0, 0, 32'h1,         32'd2);
`ifndef EXEC_MUL_EN
    add_vec("mul_off",  3'b111, 32'd6,        32'd7,        32'd0, 0, 2'b00, 2'b00, 32'd0,     32'd0, 0, 32'h0,         32'd7);
`endif

    drive_idle();
    reset = 1'b1;
    step(); step();
    chk_bubble("reset_init");
    chk("reset_stall", {31'd0, stallE}, 32'h0);
    @(negedge clk); reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk({vecs[i].name, "_wregE"}, {27'd0, WriteRegE}, {27'd0, vecs[i].exp_wreg});
      chk({vecs[i].name, "_stall"}, {31'd0, stallE}, 32'h0);
      step();
      chk({vecs[i].name, "_alu"}, ALUOutM, vecs[i].exp_alu);
      chk({vecs[i].name, "_wd"}, WriteDataM, vecs[i].exp_wd);
      chk({vecs[i].name, "_wreg"}, {27'd0, WriteRegM}, {27'd0, vecs[i].exp_wreg});
      chk({vecs[i].name, "_ctl"}, {29'd0, MemToRegM, MemWriteM, RegWM},
          {29'd0, vecs[i].memtoreg, vecs[i].memwrite, vecs[i].regw});
    end

    // Reset held two cycles mid-stream, then an add right after release.
    @(negedge clk);
    apply(vecs[0]);
    reset = 1'b1;
    step();
    chk_bubble("reset_mid1");
    step();
    chk_bubble("reset_mid2");
    chk("reset_mid_stall", {31'd0, stallE}, 32'h0);
    @(negedge clk); reset = 1'b0;
    step();
    chk("post_reset_add", ALUOutM, 32'd12);

`ifdef EXEC_MUL_EN
    run_mul("mul_big", 32'h0001_0003, 32'h0002_0000, 32'h0006_0000);

    // Reset in mul cycle 10, then a fresh mul.
    drive_idle();
    ALUOPE = 3'b111; RD1E = 32'd100; RD2E = 32'd200; RegWE = 1;
    for (int c = 0; c < 10; c++) step();
    @(negedge clk);
    drive_idle(); RegWE = 1; reset = 1'b1;
    step();
    chk_bubble("mul_reset");
    chk("mul_reset_stall", {31'd0, stallE}, 32'h0);
    @(negedge clk); reset = 1'b0;
    run_mul("mul_6x7", 32'd6, 32'd7, 32'd42);
    run_mul("mul_b2b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past limit");
    $fatal(1, "timeout");
  end

endmodule
